// File: rtl/lc3b_regfile_cc.sv
// LC-3b register file (R0-R7) with N/Z/P condition codes and registered BEN.
// Define LC3B_REGFILE_BYPASS_EN for write-first forwarding of bus onto the read ports.
module lc3b_regfile_cc #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [$clog2(NREGS)-1:0] sr1,
  input  logic [$clog2(NREGS)-1:0] sr2,
  output logic [WIDTH-1:0]         sr1_out,
  output logic [WIDTH-1:0]         sr2_out,
  input  logic [$clog2(NREGS)-1:0] dr,
  input  logic                     ld_reg,
  input  logic [WIDTH-1:0]         bus,
  input  logic                     ld_cc,
  input  logic [2:0]               ir_nzp,
  input  logic                     ld_ben,
  output logic [2:0]               nzp,
  output logic                     ben
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [2:0]       nzp_next;

  always_comb begin
    nzp_next[2] = bus[WIDTH-1];
    nzp_next[1] = (bus == '0);
    nzp_next[0] = !bus[WIDTH-1] && (bus != '0);
  end

  // BEN samples the stored flags, so a same-edge ld_cc does not affect it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      nzp <= 3'b010;
      ben <= 1'b0;
    end else begin
      if (ld_reg) regs[dr] <= bus;
      if (ld_cc)  nzp <= nzp_next;
      if (ld_ben) ben <= |(ir_nzp & nzp);
    end
  end

`ifdef LC3B_REGFILE_BYPASS_EN
  assign sr1_out = (ld_reg && (sr1 == dr)) ? bus : regs[sr1];
  assign sr2_out = (ld_reg && (sr2 == dr)) ? bus : regs[sr2];
`else
  assign sr1_out = regs[sr1];
  assign sr2_out = regs[sr2];
`endif

endmodule

// File: tb/tb_lc3b_regfile_cc.sv
// Self-checking bench for lc3b_regfile_cc: directed steps plus random traffic
// compared against an array-based reference model.
module tb_lc3b_regfile_cc;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  sr1 = '0, sr2 = '0, dr = '0, ir_nzp = '0;
  logic [15:0] sr1_out, sr2_out, bus = '0;
  logic        ld_reg = 1'b0, ld_cc = 1'b0, ld_ben = 1'b0;
  logic [2:0]  nzp;
  logic        ben;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] m_r [8];
  logic [2:0]  m_nzp;
  logic        m_ben;

  lc3b_regfile_cc #(.WIDTH(16), .NREGS(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .sr1(sr1), .sr2(sr2), .sr1_out(sr1_out), .sr2_out(sr2_out),
    .dr(dr), .ld_reg(ld_reg), .bus(bus),
    .ld_cc(ld_cc), .ir_nzp(ir_nzp), .ld_ben(ld_ben),
    .nzp(nzp), .ben(ben)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] cc_of(input logic [15:0] v);
    if (v[15])         return 3'b100;
    else if (v == 16'd0) return 3'b010;
    else               return 3'b001;
  endfunction

  function automatic logic [15:0] exp_rd(input logic [2:0] idx);
`ifdef LC3B_REGFILE_BYPASS_EN
    if (ld_reg && idx == dr) return bus;
`endif
    return m_r[idx];
  endfunction

  function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b, input logic [1:0] k);
    case (k)
      2'b00:   return a + b;
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return a;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    m_nzp = 3'b010;
    m_ben = 1'b0;
  endtask

  task automatic cyc(input logic lr, input logic [2:0] d, input logic [15:0] b,
                     input logic lc, input logic lb, input logic [2:0] irn,
                     input logic [2:0] s1, input logic [2:0] s2);
    @(negedge clk);
    ld_reg = lr; dr = d; bus = b; ld_cc = lc; ld_ben = lb; ir_nzp = irn;
    sr1 = s1; sr2 = s2;
    #1;
    chk("rd1_pre", sr1_out, exp_rd(s1));
    chk("rd2_pre", sr2_out, exp_rd(s2));
    @(posedge clk);
    if (lb) m_ben = (irn[2] & m_nzp[2]) | (irn[1] & m_nzp[1]) | (irn[0] & m_nzp[0]);
    if (lc) m_nzp = cc_of(b);
    if (lr) m_r[d] = b;
    #1;
    chk("rd1_post", sr1_out, exp_rd(s1));
    chk("rd2_post", sr2_out, exp_rd(s2));
    chk("nzp", {13'd0, nzp}, {13'd0, m_nzp});
    chk("ben", {15'd0, ben}, {15'd0, m_ben});
  endtask

  task automatic peek(input logic [2:0] idx, input string tag, input logic [15:0] exp);
    @(negedge clk);
    ld_reg = 1'b0; ld_cc = 1'b0; ld_ben = 1'b0; sr1 = idx;
    #1 chk(tag, sr1_out, exp);
  endtask

  task automatic read_all();
    @(negedge clk);
    ld_reg = 1'b0; ld_cc = 1'b0; ld_ben = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i);
      #1;
      chk("sweep1", sr1_out, m_r[i]);
      chk("sweep2", sr2_out, m_r[7 - i]);
    end
  endtask

  // Assert reset between edges, try a write across an edge while held, then release.
  task automatic do_reset();
    @(posedge clk);
    #2;
    ld_reg = 1'b0; ld_cc = 1'b0; ld_ben = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(i);
      #0.1;
      chk("rst_rd1", sr1_out, 16'h0000);
      chk("rst_rd2", sr2_out, 16'h0000);
    end
    chk("rst_nzp", {13'd0, nzp}, 16'h0002);
    chk("rst_ben", {15'd0, ben}, 16'h0000);
    ld_reg = 1'b1; dr = 3'd3; bus = 16'hFFFF; ld_cc = 1'b1; ld_ben = 1'b1; ir_nzp = 3'b111;
    @(posedge clk);
    #1;
    ld_reg = 1'b0; ld_cc = 1'b0; ld_ben = 1'b0; sr1 = 3'd3;
    #1;
    chk("rst_discard", sr1_out, 16'h0000);
    chk("rst_hold_nzp", {13'd0, nzp}, 16'h0002);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] v;
    model_reset();
    do_reset();
    read_all();

    for (int i = 0; i < 8; i++)
      cyc(1'b1, 3'(i), 16'(16'h1111 * i), 1'b0, 1'b0, 3'b000, 3'(i), 3'd0);
    read_all();
    chk("r7_const", m_r[7], 16'h7777);
    cyc(1'b0, 3'd2, 16'hDEAD, 1'b0, 1'b0, 3'b000, 3'd2, 3'd5);
    read_all();
    peek(3'd2, "no_write_r2", 16'h2222);

    cyc(1'b0, 3'd0, 16'h8000, 1'b1, 1'b0, 3'b000, 3'd0, 3'd1);
    chk("cc_neg", {13'd0, nzp}, 16'h0004);
    cyc(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'b000, 3'd0, 3'd1);
    chk("cc_zero", {13'd0, nzp}, 16'h0002);
    cyc(1'b0, 3'd0, 16'h7FFF, 1'b1, 1'b0, 3'b000, 3'd0, 3'd1);
    chk("cc_pos", {13'd0, nzp}, 16'h0001);
    cyc(1'b0, 3'd0, 16'h8000, 1'b0, 1'b0, 3'b000, 3'd0, 3'd1);
    chk("cc_hold", {13'd0, nzp}, 16'h0001);

    cyc(1'b1, 3'd1, 16'h000C, 1'b0, 1'b0, 3'b000, 3'd1, 3'd2);
    cyc(1'b1, 3'd2, 16'h000A, 1'b0, 1'b0, 3'b000, 3'd1, 3'd2);
    v = alu(m_r[1], m_r[2], 2'b00);
    cyc(1'b1, 3'd3, v, 1'b1, 1'b0, 3'b000, 3'd1, 3'd2);
    peek(3'd3, "alu_add", 16'h0016);
    chk("alu_add_nzp", {13'd0, nzp}, 16'h0001);
    v = alu(m_r[1], m_r[2], 2'b10);
    cyc(1'b1, 3'd3, v, 1'b1, 1'b0, 3'b000, 3'd1, 3'd2);
    peek(3'd3, "alu_xor", 16'h0006);
    chk("alu_xor_nzp", {13'd0, nzp}, 16'h0001);

    cyc(1'b0, 3'd0, 16'h8000, 1'b1, 1'b0, 3'b000, 3'd0, 3'd0);
    cyc(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'b011, 3'd0, 3'd0);
    chk("ben_011", {15'd0, ben}, 16'h0000);
    cyc(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'b100, 3'd0, 3'd0);
    chk("ben_100", {15'd0, ben}, 16'h0001);
    cyc(1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'b010, 3'd0, 3'd0);
    chk("ben_old_n", {15'd0, ben}, 16'h0000);
    chk("ben_nzp_new", {13'd0, nzp}, 16'h0002);

    cyc(1'b1, 3'd5, 16'h0001, 1'b0, 1'b0, 3'b000, 3'd5, 3'd0);
    @(negedge clk);
    ld_reg = 1'b1; dr = 3'd5; bus = 16'hBEEF; ld_cc = 1'b0; ld_ben = 1'b0; sr1 = 3'd5;
    #1;
`ifdef LC3B_REGFILE_BYPASS_EN
    chk("same_cycle_r5", sr1_out, 16'hBEEF);
`else
    chk("same_cycle_r5", sr1_out, 16'h0001);
`endif
    @(posedge clk);
    m_r[5] = 16'hBEEF;
    #1;
    peek(3'd5, "after_edge_r5", 16'hBEEF);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset();
      end else begin
        case ($urandom_range(0, 3))
          0:       v = 16'h0000;
          1:       v = 16'h8000;
          2:       v = 16'h7FFF;
          default: v = 16'($urandom);
        endcase
        cyc(1'($urandom), 3'($urandom), v, 1'($urandom), 1'($urandom),
            3'($urandom), 3'($urandom), 3'($urandom));
      end
    end
    read_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
